// File: rtl/ofs_asp_pkg.sv
// Shared types, CSR word offsets and byte-lane merge helper for the ASP MMIO64 CSR responder.
package ofs_asp_pkg;

  typedef logic [63:0] t_mmio64_data;

  localparam logic [3:0] MMIO_CSR_DFH         = 4'h0;
  localparam logic [3:0] MMIO_CSR_ID_L        = 4'h1;
  localparam logic [3:0] MMIO_CSR_ID_H        = 4'h2;
  localparam logic [3:0] MMIO_CSR_SCRATCH     = 4'h3;
  localparam logic [3:0] MMIO_CSR_CTRL        = 4'h4;
  localparam logic [3:0] MMIO_CSR_STATUS      = 4'h5;
  localparam logic [3:0] MMIO_CSR_DOORBELL    = 4'h6;
  localparam logic [3:0] MMIO_CSR_CYCLE_COUNT = 4'h7;
  localparam logic [3:0] MMIO_CSR_ERR_COUNT   = 4'h8;

  function automatic t_mmio64_data apply_byteenable(input t_mmio64_data old_v,
                                                    input t_mmio64_data new_v,
                                                    input logic [7:0]   be);
    t_mmio64_data res;
    for (int i = 0; i < 8; i++) begin
      res[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ofs_asp_mmio_rd_pipe.sv
// Fixed-depth valid/data shift pipeline for MMIO read responses; synchronous flush drops
// everything in flight. Data lanes are forced to zero whenever the matching valid is low.
module ofs_asp_mmio_rd_pipe
  import ofs_asp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         flush_i,
  input  logic         valid_i,
  input  t_mmio64_data data_i,
  output logic         valid_o,
  output t_mmio64_data data_o
);

  logic [DEPTH-1:0] valid_q;
  t_mmio64_data     data_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      data_q[0]  <= valid_i ? data_i : '0;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/ofs_asp_mmio64_csr_responder.sv
// Avalon-MM sink for the host 64-bit MMIO channel: small CSR file with fixed-latency reads.
// Optional saturating error counter at word 0x8 is built when ASP_MMIO_ERR_COUNT_EN is defined.
module ofs_asp_mmio64_csr_responder
  import ofs_asp_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 16,
  parameter int          READ_LATENCY = 2,
  parameter logic [63:0] DFH_VALUE    = 64'h1000_0000_0000_1000,
  parameter logic [63:0] AFU_ID_L     = 64'h0,
  parameter logic [63:0] AFU_ID_H     = 64'h0
) (
  input  logic                  pClk,
  input  logic                  pClk_reset,
  input  logic [ADDR_WIDTH-1:0] avmm_address,
  input  logic                  avmm_read,
  input  logic                  avmm_write,
  input  logic [63:0]           avmm_writedata,
  input  logic [7:0]            avmm_byteenable,
  output logic                  avmm_waitrequest,
  output logic [63:0]           avmm_readdata,
  output logic                  avmm_readdatavalid,
  output logic [63:0]           ctrl_out,
  input  logic [63:0]           status_in,
  output logic                  doorbell_pulse,
  output logic [63:0]           doorbell_data
);

  logic         wait_q;
  logic         hold_q;
  t_mmio64_data scratch_q;
  t_mmio64_data ctrl_q;
  t_mmio64_data status_q;
  t_mmio64_data db_data_q;
  t_mmio64_data cycle_q;
  logic         db_pulse_q;
  t_mmio64_data rd_data_d;

  logic [3:0] offset;
  logic       in_window;
  logic       rd_acc;
  logic       wr_acc;
  logic       collide;

  assign offset    = avmm_address[3:0];
  assign in_window = (avmm_address[ADDR_WIDTH-1:4] == '0);
  assign rd_acc    = avmm_read & ~wait_q;
  assign collide   = avmm_read & avmm_write & ~wait_q;
  // A write that collides with a read is dropped; the read still goes through.
  assign wr_acc    = avmm_write & ~avmm_read & ~wait_q;

`ifdef ASP_MMIO_ERR_COUNT_EN
  logic [31:0] err_q;
  logic        unmapped;
  logic        ro_hit;
  logic        err_event;
  logic        err_clear;

  assign unmapped  = ~in_window | (offset > MMIO_CSR_ERR_COUNT);
  assign ro_hit    = in_window & ((offset == MMIO_CSR_DFH)    | (offset == MMIO_CSR_ID_L) |
                                  (offset == MMIO_CSR_ID_H)   | (offset == MMIO_CSR_STATUS) |
                                  (offset == MMIO_CSR_CYCLE_COUNT));
  assign err_event = collide | (rd_acc & unmapped) | (wr_acc & (unmapped | ro_hit));
  assign err_clear = wr_acc & in_window & (offset == MMIO_CSR_ERR_COUNT);

  always_ff @(posedge pClk) begin
    if (pClk_reset) begin
      err_q <= '0;
    end else if (err_clear) begin
      err_q <= '0;
    end else if (err_event && (err_q != '1)) begin
      err_q <= err_q + 32'd1;
    end
  end
`endif

  always_comb begin
    rd_data_d = '0;
    if (in_window) begin
      case (offset)
        MMIO_CSR_DFH:         rd_data_d = DFH_VALUE;
        MMIO_CSR_ID_L:        rd_data_d = AFU_ID_L;
        MMIO_CSR_ID_H:        rd_data_d = AFU_ID_H;
        MMIO_CSR_SCRATCH:     rd_data_d = scratch_q;
        MMIO_CSR_CTRL:        rd_data_d = ctrl_q;
        MMIO_CSR_STATUS:      rd_data_d = status_q;
        MMIO_CSR_DOORBELL:    rd_data_d = db_data_q;
        MMIO_CSR_CYCLE_COUNT: rd_data_d = cycle_q;
`ifdef ASP_MMIO_ERR_COUNT_EN
        MMIO_CSR_ERR_COUNT:   rd_data_d = {32'h0, err_q};
`endif
        default:              rd_data_d = '0;
      endcase
    end
  end

  // waitrequest stays up through the reset cycle plus one more, via hold_q.
  always_ff @(posedge pClk) begin
    if (pClk_reset) begin
      hold_q     <= 1'b1;
      wait_q     <= 1'b1;
      scratch_q  <= '0;
      ctrl_q     <= '0;
      status_q   <= '0;
      db_data_q  <= '0;
      db_pulse_q <= 1'b0;
      cycle_q    <= '0;
    end else begin
      hold_q     <= 1'b0;
      wait_q     <= hold_q;
      status_q   <= status_in;
      cycle_q    <= cycle_q + 64'd1;
      db_pulse_q <= 1'b0;
      if (wr_acc && in_window) begin
        case (offset)
          MMIO_CSR_SCRATCH:  scratch_q <= apply_byteenable(scratch_q, avmm_writedata, avmm_byteenable);
          MMIO_CSR_CTRL:     ctrl_q    <= apply_byteenable(ctrl_q, avmm_writedata, avmm_byteenable);
          MMIO_CSR_DOORBELL: begin
            db_data_q  <= apply_byteenable(db_data_q, avmm_writedata, avmm_byteenable);
            db_pulse_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  ofs_asp_mmio_rd_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_rd_pipe (
    .clk_i   (pClk),
    .flush_i (pClk_reset),
    .valid_i (rd_acc),
    .data_i  (rd_data_d),
    .valid_o (avmm_readdatavalid),
    .data_o  (avmm_readdata)
  );

  assign avmm_waitrequest = wait_q;
  assign ctrl_out         = ctrl_q;
  assign doorbell_pulse   = db_pulse_q;
  assign doorbell_data    = db_data_q;

endmodule

// File: tb/tb_ofs_asp_mmio64_csr_responder.sv
// Self-checking bench for the MMIO64 CSR responder against a register-map reference model.
module tb_ofs_asp_mmio64_csr_responder;

  localparam int          LAT  = 2;
  localparam logic [63:0] DFH  = 64'h1000_0000_0000_1000;
  localparam logic [63:0] IDL  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] IDH  = 64'hFEDC_BA98_7654_3210;

  logic        clk = 1'b0;
  logic        pClk_reset = 1'b1;
  logic [15:0] avmm_address = '0;
  logic        avmm_read = 1'b0;
  logic        avmm_write = 1'b0;
  logic [63:0] avmm_writedata = '0;
  logic [7:0]  avmm_byteenable = '0;
  logic        avmm_waitrequest;
  logic [63:0] avmm_readdata;
  logic        avmm_readdatavalid;
  logic [63:0] ctrl_out;
  logic [63:0] status_in = '0;
  logic        doorbell_pulse;
  logic [63:0] doorbell_data;

  ofs_asp_mmio64_csr_responder #(
    .ADDR_WIDTH   (16),
    .READ_LATENCY (LAT),
    .DFH_VALUE    (DFH),
    .AFU_ID_L     (IDL),
    .AFU_ID_H     (IDH)
  ) dut (
    .pClk               (clk),
    .pClk_reset         (pClk_reset),
    .avmm_address       (avmm_address),
    .avmm_read          (avmm_read),
    .avmm_write         (avmm_write),
    .avmm_writedata     (avmm_writedata),
    .avmm_byteenable    (avmm_byteenable),
    .avmm_waitrequest   (avmm_waitrequest),
    .avmm_readdata      (avmm_readdata),
    .avmm_readdatavalid (avmm_readdatavalid),
    .ctrl_out           (ctrl_out),
    .status_in          (status_in),
    .doorbell_pulse     (doorbell_pulse),
    .doorbell_data      (doorbell_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int          edge_cnt = 0;
  int          rst_edge = 0;
  logic [63:0] stat_cur = '0;

  always @(posedge clk) begin
    edge_cnt = edge_cnt + 1;
    if (pClk_reset) rst_edge = edge_cnt;
    stat_cur = status_in;
  end

  logic [63:0] rsp_data[$];
  int          rsp_edge[$];
  logic [63:0] exp_data[$];
  int          exp_edge[$];

  always @(negedge clk) begin
    if (avmm_readdatavalid) begin
      rsp_data.push_back(avmm_readdata);
      rsp_edge.push_back(edge_cnt);
    end
  end

  // Reference register state
  logic [63:0] m_scratch = '0;
  logic [63:0] m_ctrl    = '0;
  logic [63:0] m_db      = '0;
  logic [31:0] m_err     = '0;

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = o;
    for (int i = 0; i < 8; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  function automatic bit is_unmapped(input logic [15:0] a);
`ifdef ASP_MMIO_ERR_COUNT_EN
    return a > 16'd8;
`else
    return a > 16'd7;
`endif
  endfunction

  function automatic bit is_ro(input logic [15:0] a);
    return a == 16'd0 || a == 16'd1 || a == 16'd2 || a == 16'd5 || a == 16'd7;
  endfunction

  function automatic logic [63:0] model_read(input logic [15:0] a, input int e);
    if (is_unmapped(a)) return 64'h0;
    case (a)
      16'd0: return DFH;
      16'd1: return IDL;
      16'd2: return IDH;
      16'd3: return m_scratch;
      16'd4: return m_ctrl;
      16'd5: return stat_cur;
      16'd6: return m_db;
      16'd7: return 64'(e - rst_edge - 1);
      default: return {32'h0, m_err};
    endcase
  endfunction

  task automatic bump_err();
`ifdef ASP_MMIO_ERR_COUNT_EN
    if (m_err != 32'hFFFF_FFFF) m_err = m_err + 32'd1;
`endif
  endtask

  task automatic model_reset();
    m_scratch = '0; m_ctrl = '0; m_db = '0; m_err = '0;
    exp_data.delete(); exp_edge.delete();
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [63:0] d, input logic [7:0] be);
    int e;
    @(negedge clk);
    avmm_read = rd; avmm_write = wr; avmm_address = a;
    avmm_writedata = d; avmm_byteenable = be;
    e = edge_cnt + 1;
    if (rd) begin
      exp_data.push_back(model_read(a, e));
      exp_edge.push_back(e + LAT - 1);
    end
    if (rd && wr) bump_err();
    else if (rd && is_unmapped(a)) bump_err();
    else if (wr) begin
      if (is_unmapped(a) || is_ro(a)) bump_err();
      else case (a)
        16'd3: m_scratch = merge(m_scratch, d, be);
        16'd4: m_ctrl    = merge(m_ctrl, d, be);
        16'd6: m_db      = merge(m_db, d, be);
        16'd8: m_err     = '0;
        default: ;
      endcase
    end
  endtask

  task automatic idle();
    @(negedge clk);
    avmm_read = 1'b0; avmm_write = 1'b0; avmm_byteenable = '0;
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (rsp_data.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    pClk_reset = 1'b1; avmm_read = 1'b0; avmm_write = 1'b0;
    repeat (2) @(negedge clk);
    pClk_reset = 1'b0;
    model_reset();
    rsp_data.delete(); rsp_edge.delete();
    total += 6;
    if (avmm_waitrequest !== 1'b1) begin bad++; $display("FAIL rst_wait got %b want 1", avmm_waitrequest); end
    if (avmm_readdatavalid !== 1'b0) begin bad++; $display("FAIL rst_rdv got %b want 0", avmm_readdatavalid); end
    if (avmm_readdata !== 64'h0) begin bad++; $display("FAIL rst_rdata got %h want 0", avmm_readdata); end
    if (ctrl_out !== 64'h0) begin bad++; $display("FAIL rst_ctrl got %h want 0", ctrl_out); end
    if (doorbell_pulse !== 1'b0) begin bad++; $display("FAIL rst_dbp got %b want 0", doorbell_pulse); end
    if (doorbell_data !== 64'h0) begin bad++; $display("FAIL rst_dbd got %h want 0", doorbell_data); end
    @(negedge clk);
    total++;
    if (avmm_waitrequest !== 1'b1) begin bad++; $display("FAIL wait_post1 got %b want 1", avmm_waitrequest); end
    @(negedge clk);
    total++;
    if (avmm_waitrequest !== 1'b0) begin bad++; $display("FAIL wait_post2 got %b want 0", avmm_waitrequest); end
  endtask

  task automatic test_dfh_read();
    bit ok;
    issue(1'b1, 1'b0, 16'h0, '0, '0);
    idle();
    wait_rsp(1, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL dfh_timeout got %0d rsp want 1", rsp_data.size()); end
    else begin
      total += 2;
      if (rsp_data[0] !== 64'h1000_0000_0000_1000) begin bad++; $display("FAIL dfh_data got %h want %h", rsp_data[0], 64'h1000_0000_0000_1000); end
      if (rsp_edge[0] !== exp_edge[0]) begin bad++; $display("FAIL dfh_latency got edge %0d want %0d", rsp_edge[0], exp_edge[0]); end
    end
    rsp_data.delete(); rsp_edge.delete(); exp_data.delete(); exp_edge.delete();
  endtask

  task automatic test_scratch_be();
    bit ok;
    issue(1'b0, 1'b1, 16'h3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    issue(1'b0, 1'b1, 16'h3, 64'h0, 8'h0F);
    issue(1'b1, 1'b0, 16'h3, '0, '0);
    idle();
    wait_rsp(1, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL scratch_timeout got %0d rsp want 1", rsp_data.size()); end
    else begin
      total++;
      if (rsp_data[0] !== 64'hFFFF_FFFF_0000_0000) begin bad++; $display("FAIL scratch_be got %h want %h", rsp_data[0], 64'hFFFF_FFFF_0000_0000); end
    end
    rsp_data.delete(); rsp_edge.delete(); exp_data.delete(); exp_edge.delete();
  endtask

  task automatic test_doorbell();
    bit ok;
    issue(1'b0, 1'b1, 16'h6, 64'hA5, 8'hFF);
    issue(1'b0, 1'b1, 16'h6, 64'h5A, 8'hFF);
    total += 2;
    if (doorbell_pulse !== 1'b1) begin bad++; $display("FAIL db_pulse1 got %b want 1", doorbell_pulse); end
    if (doorbell_data !== 64'hA5) begin bad++; $display("FAIL db_data1 got %h want a5", doorbell_data); end
    idle();
    total += 2;
    if (doorbell_pulse !== 1'b1) begin bad++; $display("FAIL db_pulse2 got %b want 1", doorbell_pulse); end
    if (doorbell_data !== 64'h5A) begin bad++; $display("FAIL db_data2 got %h want 5a", doorbell_data); end
    idle();
    total++;
    if (doorbell_pulse !== 1'b0) begin bad++; $display("FAIL db_pulse_end got %b want 0", doorbell_pulse); end
    issue(1'b1, 1'b0, 16'h6, '0, '0);
    idle();
    wait_rsp(1, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL db_rd_timeout got %0d rsp want 1", rsp_data.size()); end
    else begin
      total++;
      if (rsp_data[0] !== 64'h5A) begin bad++; $display("FAIL db_read got %h want 5a", rsp_data[0]); end
    end
    rsp_data.delete(); rsp_edge.delete(); exp_data.delete(); exp_edge.delete();
  endtask

  task automatic test_cycle_count();
    bit ok;
    for (int i = 0; i < 8; i++) issue(1'b1, 1'b0, 16'h7, '0, '0);
    idle();
    wait_rsp(8, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL cyc_timeout got %0d rsp want 8", rsp_data.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        total += 2;
        if (rsp_data[i] !== exp_data[i]) begin bad++; $display("FAIL cyc_val[%0d] got %0d want %0d", i, rsp_data[i], exp_data[i]); end
        if (rsp_edge[i] !== exp_edge[i]) begin bad++; $display("FAIL cyc_edge[%0d] got %0d want %0d", i, rsp_edge[i], exp_edge[i]); end
        if (i > 0) begin
          total++;
          if (rsp_data[i] !== rsp_data[i-1] + 64'd1) begin bad++; $display("FAIL cyc_incr[%0d] got %0d want %0d", i, rsp_data[i], rsp_data[i-1] + 64'd1); end
        end
      end
    end
    rsp_data.delete(); rsp_edge.delete(); exp_data.delete(); exp_edge.delete();
  endtask

  task automatic test_unmapped();
    bit ok;
    int n;
    issue(1'b1, 1'b0, 16'h3F, '0, '0);
    issue(1'b0, 1'b1, 16'h1, {$urandom, $urandom}, 8'hFF);
    issue(1'b1, 1'b0, 16'h1, '0, '0);
`ifdef ASP_MMIO_ERR_COUNT_EN
    issue(1'b1, 1'b0, 16'h8, '0, '0);
    issue(1'b0, 1'b1, 16'h8, 64'h1234, 8'hFF);
    issue(1'b1, 1'b0, 16'h8, '0, '0);
`endif
    idle();
    n = exp_data.size();
    wait_rsp(n, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL unm_timeout got %0d rsp want %0d", rsp_data.size(), n); end
    else begin
      total += 2;
      if (rsp_data[0] !== 64'h0) begin bad++; $display("FAIL unm_read got %h want 0", rsp_data[0]); end
      if (rsp_data[1] !== IDL) begin bad++; $display("FAIL idl_kept got %h want %h", rsp_data[1], IDL); end
`ifdef ASP_MMIO_ERR_COUNT_EN
      total += 2;
      if (rsp_data[2] !== 64'd2) begin bad++; $display("FAIL err_cnt got %0d want 2", rsp_data[2]); end
      if (rsp_data[3] !== 64'd0) begin bad++; $display("FAIL err_clr got %0d want 0", rsp_data[3]); end
`endif
    end
    rsp_data.delete(); rsp_edge.delete(); exp_data.delete(); exp_edge.delete();
  endtask

  task automatic test_random();
    bit ok;
    int n;
    for (int k = 0; k < 80; k++) begin
      int op, r;
      logic [15:0] a;
      op = $urandom_range(0, 9);
      r  = $urandom_range(0, 11);
      if (r <= 8) a = 16'(r);
      else if (r == 9) a = 16'h3F;
      else if (r == 10) a = 16'($urandom_range(16, 65535));
      else a = 16'h3;
      issue(op < 4 || op == 9, (op >= 4 && op < 8) || op == 9, a,
            {$urandom, $urandom}, 8'($urandom_range(0, 255)));
      status_in = {$urandom, $urandom};
    end
    issue(1'b1, 1'b0, 16'h8, '0, '0);
    idle();
    n = exp_data.size();
    wait_rsp(n, ok);
    total++;
    if (!ok || rsp_data.size() != n) begin bad++; $display("FAIL rnd_count got %0d want %0d", rsp_data.size(), n); end
    else begin
      for (int i = 0; i < n; i++) begin
        total += 2;
        if (rsp_data[i] !== exp_data[i]) begin bad++; $display("FAIL rnd_data[%0d] got %h want %h", i, rsp_data[i], exp_data[i]); end
        if (rsp_edge[i] !== exp_edge[i]) begin bad++; $display("FAIL rnd_edge[%0d] got %0d want %0d", i, rsp_edge[i], exp_edge[i]); end
      end
    end
    total++;
    if (ctrl_out !== m_ctrl) begin bad++; $display("FAIL rnd_ctrl got %h want %h", ctrl_out, m_ctrl); end
    rsp_data.delete(); rsp_edge.delete(); exp_data.delete(); exp_edge.delete();
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 1'b1, 16'h4, 64'hDEAD_BEEF, 8'hFF);
    issue(1'b1, 1'b0, 16'h0, '0, '0);
    issue(1'b1, 1'b0, 16'h7, '0, '0);
    pClk_reset = 1'b1;
    @(negedge clk);
    avmm_read = 1'b0; avmm_write = 1'b0;
    @(negedge clk);
    pClk_reset = 1'b0;
    model_reset();
    total += 6;
    if (avmm_waitrequest !== 1'b1) begin bad++; $display("FAIL mid_wait got %b want 1", avmm_waitrequest); end
    if (avmm_readdatavalid !== 1'b0) begin bad++; $display("FAIL mid_rdv got %b want 0", avmm_readdatavalid); end
    if (avmm_readdata !== 64'h0) begin bad++; $display("FAIL mid_rdata got %h want 0", avmm_readdata); end
    if (ctrl_out !== 64'h0) begin bad++; $display("FAIL mid_ctrl got %h want 0", ctrl_out); end
    if (doorbell_pulse !== 1'b0) begin bad++; $display("FAIL mid_dbp got %b want 0", doorbell_pulse); end
    if (doorbell_data !== 64'h0) begin bad++; $display("FAIL mid_dbd got %h want 0", doorbell_data); end
    repeat (6) @(negedge clk);
    #1;
    total += 2;
    if (rsp_data.size() != 0) begin bad++; $display("FAIL mid_flush got %0d rsp want 0", rsp_data.size()); end
    if (avmm_waitrequest !== 1'b0) begin bad++; $display("FAIL mid_wait_rel got %b want 0", avmm_waitrequest); end
  endtask

  initial begin
    test_reset();
    test_dfh_read();
    test_scratch_be();
    test_doorbell();
    test_cycle_count();
    test_unmapped();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/ofs_asp_mmio64_csr_responder.md
Name: ofs_asp_mmio64_csr_responder

Overview:
- Avalon-MM responder (sink) for the host-initiated 64-bit MMIO channel delivered to the ASP through the PIM.
- Decodes single-beat host reads and writes into a small CSR file: DFH, ID, scratch, control, status, doorbell, cycle counter.
- Returns read data on a fixed-latency pipeline.
- Sits behind the MMIO interface inside the ASP and feeds control and status to kernel-side logic.

Parameters:
- ADDR_WIDTH, 16, word (8-byte) address width of the MMIO port.
- READ_LATENCY, 2, cycles from accepted read to readdatavalid; legal range 1..8.
- DFH_VALUE, 64'h1000_0000_0000_1000, device feature header returned at word 0.
- AFU_ID_L, 64'h0, low half of the AFU GUID.
- AFU_ID_H, 64'h0, high half of the AFU GUID.

Ports:
- pClk  in  1  MMIO clock.
- pClk_reset  in  1  synchronous active-high reset.
- avmm_address  in  ADDR_WIDTH  word address.
- avmm_read  in  1  read request.
- avmm_write  in  1  write request.
- avmm_writedata  in  64  write data.
- avmm_byteenable  in  8  byte lanes.
- avmm_waitrequest  out  1  responder stall.
- avmm_readdata  out  64  read data.
- avmm_readdatavalid  out  1  read response strobe.
- ctrl_out  out  64  CTRL register contents.
- status_in  in  64  kernel status, sampled every cycle.
- doorbell_pulse  out  1  one-cycle strobe on DOORBELL write.
- doorbell_data  out  64  data of the last DOORBELL write.

Behaviour:
- One clock (pClk); reset pClk_reset is synchronous, active-high.
- Reset values:
  - waitrequest=1.
  - readdatavalid=0, readdata=0.
  - ctrl_out=0, doorbell_pulse=0, doorbell_data=0.
  - scratch=0, cycle counter=0, status sample=0.
- waitrequest is held for the reset cycle and one cycle after reset deasserts, then stays 0 permanently. No other backpressure is applied.
- A request is accepted when (read|write) & ~waitrequest.
- Register map (word offsets):
  - 0x0 DFH, RO.
  - 0x1 ID_L, RO.
  - 0x2 ID_H, RO.
  - 0x3 SCRATCH, RW.
  - 0x4 CTRL, RW.
  - 0x5 STATUS, RO (registered status_in).
  - 0x6 DOORBELL, WO; reads return the last doorbell_data.
  - 0x7 CYCLE_COUNT, RO, 64-bit free-running, wraps to 0.
  - 0x8 ERR_COUNT, only when the optional feature is enabled.
- Writes:
  - Applied per byteenable lane in the cycle after acceptance.
  - Writes to RO or unmapped offsets are dropped silently.
- DOORBELL write:
  - doorbell_data updated and doorbell_pulse=1 for exactly one cycle, one cycle after acceptance.
  - Back-to-back doorbell writes produce back-to-back pulses.
- Reads:
  - Data is captured at acceptance and shifted through a READ_LATENCY-deep valid/data pipeline.
  - readdatavalid rises exactly READ_LATENCY cycles after acceptance, in order.
  - Full throughput: one read per cycle, no outstanding limit.
  - Unmapped offsets return 64'h0.
- Simultaneous read and write in one cycle (protocol violation): the read is serviced, the write is dropped, and ERR_COUNT increments if compiled in.
- Read of SCRATCH in the cycle after a write to it returns the new value (write commits before the read sample).
- Reset mid-operation: the pipeline is flushed and in-flight reads produce no readdatavalid.

Optional Feature:
- Macro ASP_MMIO_ERR_COUNT_EN.
- Defined:
  - A 32-bit saturating ERR_COUNT at 0x8, zero-extended to 64 bits on read.
  - Increments on any access to an unmapped offset, a write to an RO offset, or a simultaneous read+write.
  - A write of any value to 0x8 clears it; the clear takes priority over a same-cycle increment.
- Undefined: 0x8 is unmapped and reads 0; no counter logic is built.

Decomposition:
- ofs_asp_pkg holds: register offset localparams (MMIO_CSR_DFH … MMIO_CSR_ERR_COUNT) and a t_mmio64_data typedef of 64 bits.
- Sub-module ofs_asp_mmio_rd_pipe: parameterised depth valid/data shift pipeline with synchronous flush on reset.

Test Plan:
- Reset, then read 0x0 -> readdatavalid exactly 2 cycles after acceptance, data 64'h1000_0000_0000_1000; waitrequest=0 from the second post-reset cycle.
- Write SCRATCH 64'hFFFF_FFFF_FFFF_FFFF, then write 64'h0 with byteenable 8'h0F, then read -> 64'hFFFF_FFFF_0000_0000.
- Write DOORBELL 64'hA5, 64'h5A on consecutive cycles -> doorbell_pulse high 2 consecutive cycles, doorbell_data=5A at the end; reading 0x6 returns 64'h5A.
- 8 back-to-back reads of 0x7 -> 8 consecutive readdatavalid; values strictly increasing by 1.
- Read of 0x3F and write to 0x1 -> read data 0, ID_L unchanged. With ASP_MMIO_ERR_COUNT_EN, ERR_COUNT reads 2; write to 0x8 then read -> 0.
- Issue 2 reads, assert pClk_reset one cycle later -> no readdatavalid; all outputs return to reset values.
